// File: rtl/wasm_mem_arbiter.sv
// wasm_mem_arbiter: serialises fetch and load/store onto one memory port.
// Define MEM_ARB_BOUNDS_CHECK_EN to fault on addresses >= MEM_WORDS.
module wasm_mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 64,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4,
    parameter int MEM_WORDS    = 16384
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              fault,
    output logic [ADDR_W-1:0] fault_addr
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    // WAIT covers the enable edge plus MEM_LATENCY edges of memory pipeline
    localparam int WAIT_CYC = MEM_LATENCY + 1;
    localparam int CW = $clog2(WAIT_CYC + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYC - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    state_t            state, state_nx;
    logic [CW-1:0]     wait_cnt;
    logic [SW-1:0]     starve;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_we;
    logic              lat_fetch;
    logic              grant_f;
    logic              grant_d;
    logic              bad;
    logic [ADDR_W-1:0] sel_addr;

    always_comb begin
        grant_f  = if_req && (!d_req || starve == STARVE_MAX);
        grant_d  = d_req && !grant_f;
        sel_addr = grant_f ? if_addr : d_addr;
    end

`ifdef MEM_ARB_BOUNDS_CHECK_EN
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(MEM_WORDS);
    assign bad = ({1'b0, sel_addr} >= LIMIT);
`else
    assign bad = 1'b0;
`endif

    always_comb begin
        state_nx  = state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state)
            IDLE: begin
                if (grant_f || grant_d)
                    state_nx = bad ? DONE : ACCESS;
            end
            ACCESS: begin
                mem_en    = 1'b1;
                mem_we    = lat_we;
                mem_addr  = lat_addr;
                mem_wdata = lat_wdata;
                state_nx  = lat_we ? DONE : WAIT;
            end
            WAIT: begin
                if (wait_cnt == WAIT_LAST)
                    state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy   = (state != IDLE);
    assign if_ack = (state == DONE) && lat_fetch;
    assign d_ack  = (state == DONE) && !lat_fetch;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            starve    <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            lat_fetch <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (grant_f || grant_d) begin
                        lat_fetch <= grant_f;
                        lat_we    <= grant_d && d_we;
                        lat_addr  <= sel_addr;
                        lat_wdata <= grant_d ? d_wdata : '0;
                        if (grant_f || !if_req)
                            starve <= '0;
                        else if (starve != STARVE_MAX)
                            starve <= starve + SW'(1);
                        if (bad) begin
                            if (grant_f) if_rdata <= '0;
                            else         d_rdata  <= '0;
                        end
                    end
                end
                ACCESS: wait_cnt <= '0;
                WAIT: begin
                    wait_cnt <= wait_cnt + CW'(1);
                    if (wait_cnt == WAIT_LAST) begin
                        if (lat_fetch) if_rdata <= mem_rdata;
                        else           d_rdata  <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_ARB_BOUNDS_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault      <= 1'b0;
            fault_addr <= '0;
        end else if (state == IDLE && (grant_f || grant_d) && bad
                     && !fault) begin
            fault      <= 1'b1;
            fault_addr <= sel_addr;
        end
    end
`else
    assign fault      = 1'b0;
    assign fault_addr = '0;
`endif

endmodule

// File: tb/tb_wasm_mem_arbiter.sv
// tb_wasm_mem_arbiter: transaction-timeline model plus directed vectors
// for the fetch/data memory arbiter.
module tb_wasm_mem_arbiter;
    localparam int AW  = 16;
    localparam int DW  = 64;
    localparam int LAT = 2;
    localparam int SL  = 4;
    localparam int MW  = 16384;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          fault;
    logic [AW-1:0] fault_addr;

    wasm_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT),
        .STARVE_LIMIT(SL), .MEM_WORDS(MW)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .fault(fault), .fault_addr(fault_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_word(input int i);
        if (i == 4) return 64'h41;
        return {32'h0BAD_0000 | 32'(i), 32'(i * 3 + 7)};
    endfunction

    // Memory device: reads appear LAT edges after the enable edge
    logic [DW-1:0] mem [0:65535];
    logic [DW-1:0] pipe [0:LAT-1];
    initial for (int i = 0; i < 65536; i++) mem[i] = init_word(i);
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) pipe[0] <= mem[mem_addr];
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_rdata = pipe[LAT-1];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Reference model: one transaction at a time, tracked as a timeline
    logic [DW-1:0] mref [0:65535];
    initial for (int i = 0; i < 65536; i++) mref[i] = init_word(i);
    int            m_t = -1;
    int            m_dur = 0;
    int            m_starve = 0;
    bit            m_fetch, m_we, m_bad;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] e_ifr = '0, e_dr = '0;
    bit            e_fault = 1'b0;
    logic [AW-1:0] e_faddr = '0;
    bit            p_ifr, p_dr, p_we;
    logic [AW-1:0] p_ia, p_da;
    logic [DW-1:0] p_wd;

    task automatic model_reset();
        m_t = -1;
        m_starve = 0;
        e_ifr = '0;
        e_dr = '0;
        e_fault = 1'b0;
        e_faddr = '0;
    endtask

    task automatic model_step();
        if (m_t < 0) begin
            if (p_ifr || p_dr) begin
                m_fetch = p_ifr && (!p_dr || m_starve == SL);
                if (m_fetch || !p_ifr) m_starve = 0;
                else if (m_starve < SL) m_starve++;
                m_we    = !m_fetch && p_we;
                m_addr  = m_fetch ? p_ia : p_da;
                m_wdata = p_wd;
                m_bad   = BOUNDS && (int'(m_addr) >= MW);
                m_dur   = m_bad ? 1 : (m_we ? 2 : LAT + 3);
                m_t     = 1;
            end
        end else if (m_t == m_dur) begin
            m_t = -1;
        end else begin
            m_t++;
        end
        if (m_t > 0 && m_t == m_dur) begin
            if (m_bad) begin
                if (m_fetch) e_ifr = '0; else e_dr = '0;
                if (!e_fault) e_faddr = m_addr;
                e_fault = 1'b1;
            end else if (m_we) begin
                mref[m_addr] = m_wdata;
            end else if (m_fetch) begin
                e_ifr = mref[m_addr];
            end else begin
                e_dr = mref[m_addr];
            end
        end
    endtask

    initial begin
        bit e_en, e_done;
        forever begin
            @(negedge clk);
            if (!reset) model_reset();
            else model_step();
            e_en   = (m_t == 1) && !m_bad;
            e_done = (m_t > 0) && (m_t == m_dur);
            chk("busy", busy, 64'(m_t > 0));
            chk("if_ack", if_ack, 64'(e_done && m_fetch));
            chk("d_ack", d_ack, 64'(e_done && !m_fetch));
            chk("mem_en", mem_en, 64'(e_en));
            chk("mem_we", mem_we, 64'(e_en && m_we));
            if (e_en) chk("mem_addr", mem_addr, 64'(m_addr));
            if (e_en && m_we) chk("mem_wdata", mem_wdata, m_wdata);
            if (!reset) begin
                chk("rst_mem_addr", mem_addr, '0);
                chk("rst_mem_wdata", mem_wdata, '0);
            end
            chk("if_rdata", if_rdata, e_ifr);
            chk("d_rdata", d_rdata, e_dr);
            chk("fault", fault, 64'(e_fault));
            chk("fault_addr", fault_addr, 64'(e_faddr));
            p_ifr = if_req;
            p_dr  = d_req;
            p_we  = d_we;
            p_ia  = if_addr;
            p_da  = d_addr;
            p_wd  = d_wdata;
        end
    end

    // Issue one request from posedge+1; drop it at the edge sampling ack
    task automatic access(input bit f, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, output logic [DW-1:0] rd,
                          output int lat);
        int  c0;
        bit  got;
        c0 = cyc;
        if (f) begin
            if_addr = a;
            if_req  = 1'b1;
        end else begin
            d_addr  = a;
            d_we    = we;
            d_wdata = wd;
            d_req   = 1'b1;
        end
        got = 1'b0;
        rd  = '0;
        lat = -1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (f ? if_ack : d_ack) begin
                got = 1'b1;
                lat = cyc - c0;
                rd  = f ? if_rdata : d_rdata;
            end
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ack_timeout: got no ack expected ack within 60 cycles");
        end
        @(posedge clk);
        #1;
        if (f) if_req = 1'b0;
        else   d_req  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish by 100000");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] rd, rd2;
        int            lat, lat2, cd, cf, nack, budget;
        logic [9:0]    order;
        reset = 1'b1;
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_rdata", d_rdata, 0);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        access(1'b1, 1'b0, 16'h0004, '0, rd, lat);
        chk("fetch_rdata", rd, 64'h41);
        chk("fetch_lat", 64'(lat), 64'(LAT + 3));

        access(1'b0, 1'b1, 16'h0010, 64'hDEAD_BEEF, rd, lat);
        chk("write_lat", 64'(lat), 2);
        access(1'b0, 1'b0, 16'h0010, '0, rd, lat);
        chk("readback", rd, 64'hDEAD_BEEF);
        access(1'b0, 1'b0, 16'h0023, '0, rd, lat);
        chk("read_23", rd, init_word(16'h23));

        do_reset();
        cd = 0;
        cf = 0;
        fork
            begin
                access(1'b0, 1'b0, 16'h0010, '0, rd, lat);
                cd = cyc - 1;
            end
            begin
                access(1'b1, 1'b0, 16'h0004, '0, rd2, lat2);
                cf = cyc - 1;
            end
        join
        chk("sim_d_first", rd, 64'hDEAD_BEEF);
        chk("sim_f_second", rd2, 64'h41);
        chk("sim_gap", 64'(cf - cd), 64'(LAT + 4));

        if_addr = 16'h0004;
        d_addr  = 16'h0010;
        d_we    = 1'b0;
        if_req  = 1'b1;
        d_req   = 1'b1;
        nack    = 0;
        budget  = 0;
        order   = '0;
        while (nack < 10 && budget < 300) begin
            @(negedge clk);
            budget++;
            if (if_ack || d_ack) begin
                order[nack] = if_ack;
                nack++;
            end
        end
        @(posedge clk);
        #1;
        if_req = 1'b0;
        d_req  = 1'b0;
        chk("starve_acks", 64'(nack), 10);
        chk("starve_order", 64'(order), 64'h210);

        access(1'b0, 1'b0, 16'h0011, '0, rd, lat);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b0;
        d_req = 1'b0;
        #1;
        chk("rstw_busy", busy, 0);
        chk("rstw_mem_en", mem_en, 0);
        chk("rstw_d_rdata", d_rdata, 0);
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        nack = 0;
        repeat (10) begin
            @(negedge clk);
            if (if_ack || d_ack) nack++;
        end
        chk("rstw_no_ack", 64'(nack), 0);
        @(posedge clk);
        #1;
        access(1'b1, 1'b0, 16'h0004, '0, rd, lat);
        chk("rstw_after", rd, 64'h41);

`ifdef MEM_ARB_BOUNDS_CHECK_EN
        access(1'b0, 1'b0, 16'h8000, '0, rd, lat);
        chk("oob_rdata", rd, 0);
        chk("oob_lat", 64'(lat), 1);
        chk("oob_fault", fault, 1);
        chk("oob_faddr", fault_addr, 64'h8000);
        access(1'b0, 1'b1, 16'hC000, 64'h1234, rd, lat);
        chk("oob_faddr_keep", fault_addr, 64'h8000);
`endif
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
